tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of channels (slots) per frame; legal range 2..16.
REQ-002 The block SHALL have parameter W, default 8, meaning the sample width in bits.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port in_valid  input  1  marks a sample present on in_data this cycle.
REQ-006 Port in_sof  input  1  marks start of frame (slot 0); meaningful only with in_valid=1.
REQ-007 Port in_data  input  W  carries the time-multiplexed sample.
REQ-008 Port ch_data  output  N_CH*W  holds the last sample per channel; channel k occupies bits [k*W +: W].
REQ-009 Port ch_valid  output  N_CH  gives a one-cycle pulse on bit k when channel k is updated.
REQ-010 Port frame_done  output  1  gives a one-cycle pulse when slot N_CH-1 of a locked frame is written.
REQ-011 Port sync_err  output  1  gives a one-cycle pulse on a framing violation.
REQ-012 Port locked  output  1  is high while the FSM is in LOCKED.

Function
REQ-013 The FSM SHALL have two states: HUNT and LOCKED.
REQ-014 In HUNT, samples with in_valid=1 and in_sof=0 SHALL be discarded without any output pulse.
REQ-015 In HUNT, in_valid=1 with in_sof=1 SHALL write the sample to channel 0, set slot to 1 (mod N_CH), and enter LOCKED.
REQ-016 In LOCKED, in_valid=1 with in_sof=0 and slot!=0 SHALL write to channel slot, then increment slot modulo N_CH.
REQ-017 In LOCKED, in_valid=1 with in_sof=1 and slot==0 SHALL write channel 0 and set slot to 1 (normal frame start).
REQ-018 In LOCKED, in_sof=1 with slot!=0 (early SOF) SHALL do all of the following:
- pulse sync_err;
- write the sample to channel 0;
- set slot to 1 and remain LOCKED (resync);
- not pulse frame_done.
REQ-019 In LOCKED, in_valid=1 with in_sof=0 and slot==0 (missing SOF) SHALL pulse sync_err, discard the sample, clear slot, and enter HUNT.
REQ-020 Cycles with in_valid=0 SHALL leave slot, state, and ch_data unchanged, and all pulses SHALL be 0; in_sof is ignored.
REQ-021 Latency: ch_data, ch_valid, frame_done, and sync_err SHALL be registered and appear on the cycle after the accepting edge.
REQ-022 Pulse and data alignment:
- ch_valid SHALL be one-hot or zero;
- frame_done SHALL coincide with ch_valid[N_CH-1];
- channels not written SHALL hold their value.
REQ-023 The slot counter SHALL be $clog2(N_CH) bits and SHALL wrap from N_CH-1 to 0; for non-power-of-2 N_CH, no other wrap is permitted.
REQ-024 For N_CH==1 the block is not required; REQ-001 bounds apply.

Reset
REQ-025 While rst_n=0, the block SHALL hold:
- state=HUNT, slot=0, locked=0;
- ch_data all 0, ch_valid=0;
- frame_done=0, sync_err=0.
REQ-026 Reset assertion mid-frame SHALL take effect immediately without a clock; after release, the first accepted sample SHALL require in_sof=1.

Structure
REQ-027 A shared package tdm_pkg SHALL hold the state enum (HUNT, LOCKED) and the default constants N_CH_DEF=4 and W_DEF=8.
REQ-028 The slot counter SHALL be a sub-module slot_counter (parameter N, with inputs inc and load1 and output cnt); all other logic SHALL be in tdm_demux.
REQ-029 The block SHALL contain no combinational path from inputs to outputs.

Verification
REQ-030 The bench SHALL cover these directed scenarios (N_CH=4, W=8):
- Normal frame: sof+0x11, 0x22, 0x33, 0x44 on consecutive cycles -> ch_data = 0x44_33_22_11; ch_valid pulses 1,2,4,8; frame_done pulses with bit 3; locked=1.
- Hunt discard: 0xAA, 0xBB without sof, then a sof frame -> no pulses for 0xAA and 0xBB; channel 0 = frame's first sample.
- Early SOF: sof+0x01, 0x02, then sof+0x10 -> sync_err pulse; ch_data[0]=0x10; next sample goes to channel 1; locked stays 1.
- Missing SOF: full frame, then 0x55 without sof -> sync_err pulse; 0x55 not written; locked=0.
- Gaps: frame with in_valid=0 bubbles (including in_sof=1 while in_valid=0) between samples -> identical result to the normal-frame scenario.
- Async reset: rst_n low after slot 2, between clock edges -> outputs 0 immediately; after release a non-sof sample is discarded.

Source files
------------

// File: rtl/tdm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : tdm_pkg                                                    |
// | Purpose : Shared types and default constants for the TDM demux.      |
// |           state_e - framing FSM states (HUNT, LOCKED)                |
// |           N_CH_DEF / W_DEF - default channel count / sample width    |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package tdm_pkg;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 8;

endpackage
`default_nettype wire

// File: rtl/slot_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : slot_counter                                               |
// | Purpose : Modulo-N slot index for the TDM demux.                     |
// | Ports   : clk, rst_n (async, active-low)                             |
// |           inc   - advance slot, wrapping N-1 -> 0                    |
// |           load1 - force slot to 1 (frame start); wins over inc       |
// |           cnt   - current slot, $clog2(N) bits                       |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module slot_counter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 load1,
  output logic [$clog2(N)-1:0] cnt
);

  localparam int            CW     = $clog2(N);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Explicit compare against N-1 so non-power-of-2 N never reaches
  // the unused upper codes.
  always_comb begin
    cnt_d = cnt_q;
    if (load1) begin
      cnt_d = C_ONE;
    end else if (inc) begin
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tdm_demux                                                  |
// | Purpose : Splits a time-multiplexed sample stream into N_CH parallel |
// |           channels, with start-of-frame hunting and resync.          |
// | Ports   : clk, rst_n (async, active-low)                             |
// |           in_valid, in_sof, in_data[W] - TDM input stream            |
// |           ch_data[N_CH*W] - last sample per channel (k at k*W +: W)  |
// |           ch_valid[N_CH]  - one-hot pulse for the channel written    |
// |           frame_done      - pulse when last slot of a frame written  |
// |           sync_err        - pulse on early or missing SOF            |
// |           locked          - FSM is in LOCKED                         |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  localparam int            SW     = $clog2(N_CH);
  localparam logic [SW-1:0] C_LAST = SW'(N_CH - 1);

  state_e              state_q,      state_d;
  logic [N_CH*W-1:0]   ch_data_q,    ch_data_d;
  logic [N_CH-1:0]     ch_valid_q,   ch_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                sync_err_q,   sync_err_d;

  logic                w_inc;
  logic                w_load1;
  logic [SW-1:0]       w_slot;

  slot_counter #(
    .N (N_CH)
  ) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc),
    .load1 (w_load1),
    .cnt   (w_slot)
  );

  // Slot is always 0 in HUNT and on a missing SOF, so "clear slot" on
  // the drop back to HUNT needs no explicit counter action.
  always_comb begin
    state_d      = state_q;
    ch_data_d    = ch_data_q;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    w_inc        = 1'b0;
    w_load1      = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_sof) begin
            ch_data_d[0 +: W] = in_data;
            ch_valid_d[0]     = 1'b1;
            w_load1           = 1'b1;
            state_d           = LOCKED;
          end
        end
        LOCKED: begin
          if (in_sof) begin
            // Normal frame start or early-SOF resync; only the latter errs.
            ch_data_d[0 +: W] = in_data;
            ch_valid_d[0]     = 1'b1;
            w_load1           = 1'b1;
            sync_err_d        = (w_slot != '0);
          end else if (w_slot != '0) begin
            ch_data_d[int'(w_slot)*W +: W] = in_data;
            ch_valid_d[w_slot]             = 1'b1;
            frame_done_d                   = (w_slot == C_LAST);
            w_inc                          = 1'b1;
          end else begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_tdm_demux                                               |
// | Purpose : Self-checking bench for tdm_demux (N_CH=4, W=8): directed  |
// |           framing scenarios with literal expectations, then random   |
// |           traffic checked every cycle against a behavioural model.   |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_tdm_demux;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_sof   = 1'b0;
  logic [W-1:0]   in_data  = '0;
  logic [N*W-1:0] ch_data;
  logic [N-1:0]   ch_valid;
  logic           frame_done;
  logic           sync_err;
  logic           locked;

  int n_tests = 0;
  int n_fail  = 0;

  tdm_demux #(.N_CH(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // Behavioural model: "in frame" flag, position in the frame, and the
  // last sample seen per channel; pulses describe the last clock edge.
  logic         m_lock  = 1'b0;
  int           m_pos   = 0;
  logic [W-1:0] m_ch [N];
  logic [N-1:0] m_vld   = '0;
  logic         m_fd    = 1'b0;
  logic         m_se    = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lock <= 1'b0;
      m_pos  <= 0;
      for (int k = 0; k < N; k++) m_ch[k] <= '0;
      m_vld  <= '0;
      m_fd   <= 1'b0;
      m_se   <= 1'b0;
    end else begin
      m_vld <= '0;
      m_fd  <= 1'b0;
      m_se  <= 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          // Any accepted SOF starts a frame; mid-frame it is an error.
          m_ch[0] <= in_data;
          m_vld   <= N'(1);
          m_pos   <= 1;
          m_se    <= m_lock && (m_pos != 0);
          m_lock  <= 1'b1;
        end else if (m_lock && m_pos == 0) begin
          m_se   <= 1'b1;
          m_lock <= 1'b0;
        end else if (m_lock) begin
          m_ch[m_pos] <= in_data;
          m_vld       <= N'(1) << m_pos;
          m_fd        <= (m_pos == N - 1);
          m_pos       <= (m_pos + 1) % N;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every negedge, DUT against model.
  always @(negedge clk) begin
    logic [N*W-1:0] exp_data;
    for (int k = 0; k < N; k++) exp_data[k*W +: W] = m_ch[k];
    chk("model ch_data",    64'(ch_data),    64'(exp_data));
    chk("model ch_valid",   64'(ch_valid),   64'(m_vld));
    chk("model frame_done", 64'(frame_done), 64'(m_fd));
    chk("model sync_err",   64'(sync_err),   64'(m_se));
    chk("model locked",     64'(locked),     64'(m_lock));
  end

  // Drive one cycle; outputs reflecting it are stable on return.
  task automatic step(input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [N-1:0] v, input logic fd,
                            input logic se, input logic lk);
    chk({nm, " ch_valid"},   64'(ch_valid),   64'(v));
    chk({nm, " frame_done"}, 64'(frame_done), 64'(fd));
    chk({nm, " sync_err"},   64'(sync_err),   64'(se));
    chk({nm, " locked"},     64'(locked),     64'(lk));
  endtask

  initial begin
    int pos;
    logic v, s;

    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("reset ch_data", 64'(ch_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal frame
    step(1, 1, 8'h11); expect_out("norm s0", 4'h1, 0, 0, 1);
    step(1, 0, 8'h22); expect_out("norm s1", 4'h2, 0, 0, 1);
    step(1, 0, 8'h33); expect_out("norm s2", 4'h4, 0, 0, 1);
    step(1, 0, 8'h44); expect_out("norm s3", 4'h8, 1, 0, 1);
    chk("norm ch_data", 64'(ch_data), 64'h44332211);

    // Missing SOF
    step(1, 0, 8'h55); expect_out("miss", 4'h0, 0, 1, 0);
    chk("miss ch_data", 64'(ch_data), 64'h44332211);

    // Hunt discard
    step(1, 0, 8'hAA); expect_out("hunt AA", 4'h0, 0, 0, 0);
    step(1, 0, 8'hBB); expect_out("hunt BB", 4'h0, 0, 0, 0);
    step(1, 1, 8'hC1); expect_out("hunt s0", 4'h1, 0, 0, 1);
    step(1, 0, 8'hC2);
    step(1, 0, 8'hC3);
    step(1, 0, 8'hC4); expect_out("hunt s3", 4'h8, 1, 0, 1);
    chk("hunt ch_data", 64'(ch_data), 64'hC4C3C2C1);

    // Early SOF
    step(1, 1, 8'h01);
    step(1, 0, 8'h02); expect_out("early s1", 4'h2, 0, 0, 1);
    step(1, 1, 8'h10); expect_out("early sof", 4'h1, 0, 1, 1);
    chk("early ch_data", 64'(ch_data), 64'hC4C30210);
    step(1, 0, 8'h20); expect_out("early next", 4'h2, 0, 0, 1);
    step(1, 0, 8'h30);
    step(1, 0, 8'h40); expect_out("early s3", 4'h8, 1, 0, 1);
    chk("early ch_data2", 64'(ch_data), 64'h40302010);

    // Gaps, with in_sof toggling during bubbles
    step(1, 1, 8'h11);
    step(0, 1, 8'hFF); expect_out("gap b0", 4'h0, 0, 0, 1);
    step(1, 0, 8'h22);
    step(0, 0, 8'h00);
    step(0, 1, 8'h99); expect_out("gap b2", 4'h0, 0, 0, 1);
    step(1, 0, 8'h33); expect_out("gap s2", 4'h4, 0, 0, 1);
    step(1, 0, 8'h44); expect_out("gap s3", 4'h8, 1, 0, 1);
    chk("gap ch_data", 64'(ch_data), 64'h44332211);

    // Async reset mid-frame, between edges
    step(1, 1, 8'h01);
    step(1, 0, 8'h02);
    step(1, 0, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    expect_out("arst", 4'h0, 0, 0, 0);
    chk("arst ch_data", 64'(ch_data), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 8'h77); expect_out("arst nosof", 4'h0, 0, 0, 0);
    chk("arst nosof data", 64'(ch_data), 64'h0);
    step(1, 1, 8'h5A); expect_out("arst sof", 4'h1, 0, 0, 1);
    chk("arst sof data", 64'(ch_data), 64'h5A);

    // Random traffic: mostly well-formed frames with bubbles, occasional
    // corrupted SOF flags and asynchronous resets.
    pos = 1;
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        s = (pos == 0);
        if ($urandom_range(0, 15) == 0) s = ~s;
        pos = s ? 1 : (pos + 1) % N;
      end else begin
        s = 1'($urandom_range(0, 1));
      end
      step(v, s, 8'($urandom));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk("rand arst locked", 64'(locked), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pos = 0;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
